// File: rtl/sync_bank_pkg.sv
// Shared types and constants for the multi-channel input synchronizer bank.
package sync_bank_pkg;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } deb_state_e;

  // Ceiling log2, usable in constant expressions for register widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'(1) << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_channel.sv
// One synchronizer channel: sampling chain, debounce filter, edge pulse and
// sticky pending flag.
module sync_channel
  import sync_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned EDGE_MODE     = EDGE_RISE,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic pend_o
);

  // The accepted-level register acts as the final synchronizer stage, so the
  // explicit chain holds one flop fewer than SYNC_STAGES.
  localparam int unsigned CHAIN_W = SYNC_STAGES - 1;
  localparam int unsigned CNT_W   = clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CHAIN_W-1:0] sync_q, sync_d;
  deb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lvl_q, lvl_d;
  logic               pulse_q, pulse_d;
  logic               pend_q, pend_d;
  logic               s_c;
  logic               accept_c;
  logic               edge_hit_c;

  assign sync_d = CHAIN_W'({sync_q, async_i});
  assign s_c    = sync_q[CHAIN_W-1];

  assign edge_hit_c = (EDGE_MODE == EDGE_BOTH)
                   || ((EDGE_MODE == EDGE_RISE) && s_c)
                   || ((EDGE_MODE == EDGE_FALL) && !s_c);

  // Debounce: a level change is accepted after FILTER_CYCLES consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lvl_d    = lvl_q;
    accept_c = 1'b0;
    case (state_q)
      STABLE: begin
        if (s_c != lvl_q) begin
          if (cnt_q == CNT_LAST) begin
            accept_c = 1'b1;
            lvl_d    = s_c;
            cnt_d    = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (s_c == lvl_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          accept_c = 1'b1;
          lvl_d    = s_c;
          cnt_d    = '0;
          state_d  = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
    pulse_d = accept_c && edge_hit_c;
    pend_d  = pulse_d || (pend_q && !clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      lvl_q   <= INIT_LEVEL;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
    end
  end

  assign level_o = lvl_q;
  assign pulse_o = pulse_q;
  assign pend_o  = pend_q;

endmodule

// File: rtl/sync_bank.sv
// Bank of independent input synchronizer channels with debounce and edge
// event reporting toward the CLK domain.
module sync_bank
  import sync_bank_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned EDGE_MODE     = EDGE_RISE,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N_CH-1:0] ASYNC_I,
  input  logic [N_CH-1:0] CLR_I,
  output logic [N_CH-1:0] LEVEL_O,
  output logic [N_CH-1:0] PULSE_O,
  output logic [N_CH-1:0] PEND_O
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("sync_bank: N_CH must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("sync_bank: SYNC_STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
    $error("sync_bank: FILTER_CYCLES must be in 1..255");
  end
  if (EDGE_MODE > EDGE_BOTH) begin : g_bad_edge_mode
    $error("sync_bank: EDGE_MODE must be 0 (rise), 1 (fall) or 2 (both)");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sync_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .EDGE_MODE    (EDGE_MODE),
      .INIT_LEVEL   (INIT_LEVEL)
    ) u_ch (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .async_i(ASYNC_I[g]),
      .clr_i  (CLR_I[g]),
      .level_o(LEVEL_O[g]),
      .pulse_o(PULSE_O[g]),
      .pend_o (PEND_O[g])
    );
  end

endmodule

// File: tb/tb_sync_bank.sv
// Scoreboard bench for sync_bank: three configurations sharing clock/reset,
// expected pulse cycles queued at stimulus time and matched by a monitor.
module tb_sync_bank;
  import sync_bank_pkg::*;

  typedef struct {
    int inst;
    int ch;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a0, a1, a2;
  logic [3:0] clr0;
  logic [3:0] clr_z;
  logic [3:0] lvl0, pul0, pnd0;
  logic [3:0] lvl1, pul1, pnd1;
  logic [3:0] lvl2, pul2, pnd2;

  int          cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_bank u_dut (
    .CLK(clk), .RESET(rst), .ASYNC_I(a0), .CLR_I(clr0),
    .LEVEL_O(lvl0), .PULSE_O(pul0), .PEND_O(pnd0)
  );

  sync_bank #(.EDGE_MODE(EDGE_BOTH)) u_both (
    .CLK(clk), .RESET(rst), .ASYNC_I(a1), .CLR_I(clr_z),
    .LEVEL_O(lvl1), .PULSE_O(pul1), .PEND_O(pnd1)
  );

  sync_bank #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) u_fast (
    .CLK(clk), .RESET(rst), .ASYNC_I(a2), .CLR_I(clr_z),
    .LEVEL_O(lvl2), .PULSE_O(pul2), .PEND_O(pnd2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input int ch, input int at);
    exp_t e;
    e.inst = inst;
    e.ch   = ch;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic match_pulse(input int inst, input int ch);
    int idx = -1;
    foreach (sb_q[j]) begin
      if (idx < 0 && sb_q[j].inst == inst && sb_q[j].ch == ch) idx = j;
    end
    if (idx < 0) begin
      check($sformatf("pulse_unexpected_i%0d_c%0d", inst, ch), 1, 0);
    end else begin
      check($sformatf("pulse_cycle_i%0d_c%0d", inst, ch), cyc, sb_q[idx].cyc);
      sb_q.delete(idx);
    end
  endtask

  // Every observed pulse must consume a matching scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        logic hit;
        hit = (i == 0) ? pul0[c] : (i == 1) ? pul1[c] : pul2[c];
        if (hit) match_pulse(i, c);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    a0    = 4'hF;
    a1    = 4'h0;
    a2    = 4'h0;
    clr0  = 4'h0;
    clr_z = 4'h0;

    // reset with inputs already high, then release
    tick(2);
    check("rst_level", 32'(lvl0), 0);
    check("rst_pulse", 32'(pul0), 0);
    check("rst_pend", 32'(pnd0), 0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) push_exp(0, c, cyc + 4);
    tick(3);
    check("rel_level_early", 32'(lvl0), 0);
    tick(1);
    check("rel_level", 32'(lvl0), 32'hF);
    check("rel_pulse", 32'(pul0), 32'hF);
    check("rel_pend", 32'(pnd0), 32'hF);
    tick(1);
    check("rel_pulse_one_cycle", 32'(pul0), 0);
    check("rel_pend_sticky", 32'(pnd0), 32'hF);
    a0 = 4'h0;
    tick(5);
    check("fall_level", 32'(lvl0), 0);
    clr0 = 4'hF;
    tick(1);
    clr0 = 4'h0;
    check("clr_all_pend", 32'(pnd0), 0);

    // glitch shorter than the filter
    a0[0] = 1'b1;
    tick(2);
    a0[0] = 1'b0;
    tick(6);
    check("glitch_level", 32'(lvl0[0]), 0);
    check("glitch_pend", 32'(pnd0[0]), 0);

    // held 5 cycles: one rise pulse, fall silent in rise mode
    a0[0] = 1'b1;
    push_exp(0, 0, cyc + 4);
    tick(5);
    a0[0] = 1'b0;
    tick(8);
    check("hold5_level", 32'(lvl0[0]), 0);
    check("hold5_pend", 32'(pnd0[0]), 1);

    // held exactly FILTER_CYCLES cycles is accepted
    a0[0] = 1'b1;
    push_exp(0, 0, cyc + 4);
    tick(3);
    a0[0] = 1'b0;
    tick(1);
    check("hold3_level", 32'(lvl0[0]), 1);
    tick(7);
    check("hold3_level_fall", 32'(lvl0[0]), 0);

    // clear colliding with event: set wins; lone clear drops it
    a0[2] = 1'b1;
    push_exp(0, 2, cyc + 4);
    tick(3);
    clr0[2] = 1'b1;
    tick(1);
    clr0[2] = 1'b0;
    check("collide_pend", 32'(pnd0[2]), 1);
    tick(2);
    check("collide_pend_hold", 32'(pnd0[2]), 1);
    clr0[2] = 1'b1;
    tick(1);
    clr0[2] = 1'b0;
    check("lone_clr_pend", 32'(pnd0[2]), 0);
    check("clr_other_ch", 32'(pnd0[0]), 1);

    // both-edge mode: pulses 10 cycles apart
    a1[1] = 1'b1;
    push_exp(1, 1, cyc + 4);
    tick(10);
    a1[1] = 1'b0;
    push_exp(1, 1, cyc + 4);
    tick(6);
    check("both_level", 32'(lvl1), 0);
    check("both_pend", 32'(pnd1), 32'h2);

    // reset while ch3 is mid-count
    a0[3] = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    check("midrst_level", 32'(lvl0), 0);
    check("midrst_pulse", 32'(pul0), 0);
    check("midrst_pend", 32'(pnd0), 0);
    check("midrst_pend_both", 32'(pnd1), 0);
    tick(2);
    rst = 1'b0;
    push_exp(0, 2, cyc + 4);
    push_exp(0, 3, cyc + 4);
    tick(3);
    check("midrst_level_early", 32'(lvl0), 0);
    tick(1);
    check("midrst_level_after", 32'(lvl0), 32'hC);
    check("midrst_pend_after", 32'(pnd0), 32'hC);

    // minimum latency configuration
    a2[0] = 1'b1;
    push_exp(2, 0, cyc + 3);
    tick(2);
    check("fast_level_early", 32'(lvl2), 0);
    tick(1);
    check("fast_level", 32'(lvl2[0]), 1);
    check("fast_pulse", 32'(pul2[0]), 1);

    // simultaneous events on several channels
    a2[3:1] = 3'b111;
    for (int c = 1; c < 4; c++) push_exp(2, c, cyc + 3);
    tick(4);
    check("multi_level", 32'(lvl2), 32'hF);
    check("multi_pend", 32'(pnd2), 32'hF);

    tick(3);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
